// File: rtl/b205_pwrup_seq.sv
// b205_pwrup_seq
// Power-up and re-synchronisation sequencer for the B205 clock/reset/codec
// path. It waits for the clock generator to hold lock for LOCK_HOLDOFF
// cycles, releases the bus resets, pulses the AD9364 reset for
// CAT_RST_CYCLES, waits CAT_SETTLE_CYCLES for the codec and then raises
// ready. Losing lock at any point after WAIT_LOCK restarts the sequence.
//
// Ports
//   bus_clk        in   100 MHz bus clock, all logic in this domain
//   reset_global   in   asynchronous active-high reset
//   locked         in   clock-generator lock (asynchronous, synchronised here)
//   sw_resync      in   single-cycle request to re-run the codec reset (RUN only)
//   clocks_ready   out  clocks stable (CAT_RST, CAT_SETTLE, RUN)
//   bus_rst_req    out  always !clocks_ready
//   cat_resetn     out  AD9364 RESETB, active-low (high in CAT_SETTLE, RUN)
//   cat_en         out  AD9364 ENABLE (CAT_RST, CAT_SETTLE, RUN)
//   ready          out  full sequence complete (RUN)
//   state          out  current state encoding
//   lock_lost_cnt  out  saturating count of lock-loss events
//
// Handshake: there is no valid/ready traffic here; sw_resync is a plain
// one-cycle strobe that is acted on only when sampled in RUN and is
// otherwise dropped, never held pending.
module b205_pwrup_seq #(
  parameter int LOCK_HOLDOFF      = 65535,
  parameter int CAT_RST_CYCLES    = 1000,
  parameter int CAT_SETTLE_CYCLES = 100000,
  parameter int CNT_W             = 20
) (
  input  logic       bus_clk,
  input  logic       reset_global,
  input  logic       locked,
  input  logic       sw_resync,
  output logic       clocks_ready,
  output logic       bus_rst_req,
  output logic       cat_resetn,
  output logic       cat_en,
  output logic       ready,
  output logic [2:0] state,
  output logic [7:0] lock_lost_cnt
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_LOCK  = 3'd1,
    HOLDOFF    = 3'd2,
    CAT_RST    = 3'd3,
    CAT_SETTLE = 3'd4,
    RUN        = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(LOCK_HOLDOFF - 1);
  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(CAT_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(CAT_SETTLE_CYCLES - 1);

  state_t           state_q;
  state_t           next_state;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_next;
  logic             locked_m;
  logic             locked_s;
  logic             lock_lost;
  logic             clocks_ready_d;
  logic             cat_resetn_d;
  logic             cat_en_d;
  logic             ready_d;

  // Two-flop synchroniser for the asynchronous lock input.
  always_ff @(posedge bus_clk or posedge reset_global) begin
    if (reset_global) begin
      locked_m <= 1'b0;
      locked_s <= 1'b0;
    end else begin
      locked_m <= locked;
      locked_s <= locked_m;
    end
  end

  // State register, counter, registered outputs and lock-loss counter.
  always_ff @(posedge bus_clk or posedge reset_global) begin
    if (reset_global) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      clocks_ready  <= 1'b0;
      cat_resetn    <= 1'b0;
      cat_en        <= 1'b0;
      ready         <= 1'b0;
      lock_lost_cnt <= 8'd0;
    end else begin
      state_q      <= next_state;
      cnt_q        <= cnt_next;
      clocks_ready <= clocks_ready_d;
      cat_resetn   <= cat_resetn_d;
      cat_en       <= cat_en_d;
      ready        <= ready_d;
      if (lock_lost && (lock_lost_cnt != 8'hFF)) begin
        lock_lost_cnt <= lock_lost_cnt + 8'd1;
      end
    end
  end

  // Next-state logic. Lock loss is tested before any timer exit or
  // sw_resync so it always wins a same-cycle conflict.
  always_comb begin
    next_state = state_q;
    lock_lost  = 1'b0;
    case (state_q)
      IDLE: next_state = WAIT_LOCK;
      WAIT_LOCK: begin
        if (locked_s) next_state = HOLDOFF;
      end
      HOLDOFF: begin
        if (!locked_s) begin
          next_state = WAIT_LOCK;
          lock_lost  = 1'b1;
        end else if (cnt_q == HOLD_LAST) begin
          next_state = CAT_RST;
        end
      end
      CAT_RST: begin
        if (!locked_s) begin
          next_state = WAIT_LOCK;
          lock_lost  = 1'b1;
        end else if (cnt_q == RST_LAST) begin
          next_state = CAT_SETTLE;
        end
      end
      CAT_SETTLE: begin
        if (!locked_s) begin
          next_state = WAIT_LOCK;
          lock_lost  = 1'b1;
        end else if (cnt_q == SETTLE_LAST) begin
          next_state = RUN;
        end
      end
      RUN: begin
        if (!locked_s) begin
          next_state = WAIT_LOCK;
          lock_lost  = 1'b1;
        end else if (sw_resync) begin
          next_state = CAT_RST;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Counter clears on every state entry and only advances inside the timed
  // states; the exit compare guarantees it never runs past PARAM-1.
  always_comb begin
    cnt_next = '0;
    if ((next_state == state_q) &&
        ((state_q == HOLDOFF) || (state_q == CAT_RST) || (state_q == CAT_SETTLE))) begin
      cnt_next = cnt_q + CNT_W'(1);
    end
  end

  // Output decode from next_state so the registered outputs change on the
  // same edge as the state register.
  always_comb begin
    clocks_ready_d = 1'b0;
    cat_en_d       = 1'b0;
    cat_resetn_d   = 1'b0;
    ready_d        = 1'b0;
    case (next_state)
      CAT_RST: begin
        clocks_ready_d = 1'b1;
        cat_en_d       = 1'b1;
      end
      CAT_SETTLE: begin
        clocks_ready_d = 1'b1;
        cat_en_d       = 1'b1;
        cat_resetn_d   = 1'b1;
      end
      RUN: begin
        clocks_ready_d = 1'b1;
        cat_en_d       = 1'b1;
        cat_resetn_d   = 1'b1;
        ready_d        = 1'b1;
      end
      default: ;
    endcase
  end

  assign state       = state_q;
  assign bus_rst_req = ~clocks_ready;

endmodule

// File: tb/tb_b205_pwrup_seq.sv
// Testbench for b205_pwrup_seq with LOCK_HOLDOFF=8, CAT_RST_CYCLES=4,
// CAT_SETTLE_CYCLES=6. Expected output vectors are pushed to exp_q when a
// scenario's stimulus is set up and popped one per clock edge.
module tb_b205_pwrup_seq;

  localparam int W = 16;

  logic       bus_clk = 1'b0;
  logic       reset_global = 1'b1;
  logic       locked = 1'b0;
  logic       sw_resync = 1'b0;
  logic       clocks_ready;
  logic       bus_rst_req;
  logic       cat_resetn;
  logic       cat_en;
  logic       ready;
  logic [2:0] state;
  logic [7:0] lock_lost_cnt;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs;
  logic [W-1:0] exp_v;
  int           checks = 0;
  int           errors = 0;
  int           exp_llc = 0;

  b205_pwrup_seq #(
    .LOCK_HOLDOFF(8),
    .CAT_RST_CYCLES(4),
    .CAT_SETTLE_CYCLES(6),
    .CNT_W(20)
  ) dut (
    .bus_clk(bus_clk),
    .reset_global(reset_global),
    .locked(locked),
    .sw_resync(sw_resync),
    .clocks_ready(clocks_ready),
    .bus_rst_req(bus_rst_req),
    .cat_resetn(cat_resetn),
    .cat_en(cat_en),
    .ready(ready),
    .state(state),
    .lock_lost_cnt(lock_lost_cnt)
  );

  // Clock / reset block
  always #5 bus_clk = ~bus_clk;

  assign obs = {state, clocks_ready, bus_rst_req, cat_resetn, cat_en, ready, lock_lost_cnt};

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // Expected output vector for a given state and lock-loss count.
  function automatic logic [W-1:0] exp_vec(input int st, input int llc);
    logic cr, rn, rd;
    cr = (st == 3) || (st == 4) || (st == 5);
    rn = (st == 4) || (st == 5);
    rd = (st == 5);
    return {3'(st), cr, ~cr, rn, cr, rd, 8'(llc)};
  endfunction

  // State expected e edges after lock first becomes visible to the first
  // synchroniser flop (power-up release or relock): HOLDOFF at 3,
  // CAT_RST at 11, CAT_SETTLE at 15, RUN at 21.
  function automatic int seq_state(input int e);
    if (e < 3) return 1;
    if (e < 11) return 2;
    if (e < 15) return 3;
    if (e < 21) return 4;
    return 5;
  endfunction

  // Driver tasks
  task automatic step();
    @(posedge bus_clk);
    @(negedge bus_clk);
  endtask

  task automatic release_reset();
    reset_global = 1'b1;
    @(posedge bus_clk);
    #1 reset_global = 1'b0;
  endtask

  task automatic push_relock_trace(input int n);
    for (int e = 1; e <= n; e++) exp_q.push_back(exp_vec(seq_state(e), exp_llc));
  endtask

  task automatic test_reset();
    reset_global = 1'b1;
    locked = 1'b0;
    sw_resync = 1'b0;
    step();
    step();
    checks++;
    if (obs !== exp_vec(0, 0)) begin
      errors++;
      $display("FAIL reset_values: got %h expected %h", obs, exp_vec(0, 0));
    end
  endtask

  task automatic test_powerup();
    int e;
    locked = 1'b1;
    exp_llc = 0;
    release_reset();
    push_relock_trace(22);
    e = 1;
    while (exp_q.size() > 0) begin
      step();
      exp_v = exp_q.pop_front();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL powerup edge %0d: got %h expected %h", e, obs, exp_v);
      end
      e++;
    end
  endtask

  task automatic test_resync();
    int e;
    for (int k = 1; k <= 13; k++)
      exp_q.push_back(exp_vec((k <= 4) ? 3 : (k <= 10) ? 4 : 5, exp_llc));
    sw_resync = 1'b1;
    e = 1;
    while (exp_q.size() > 0) begin
      step();
      sw_resync = 1'b0;
      exp_v = exp_q.pop_front();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL resync edge %0d: got %h expected %h", e, obs, exp_v);
      end
      e++;
    end
  endtask

  task automatic test_lock_loss();
    int e;
    locked = 1'b0;
    step();
    step();
    checks++;
    if (obs !== exp_vec(5, exp_llc)) begin
      errors++;
      $display("FAIL lock_loss_latency: got %h expected %h", obs, exp_vec(5, exp_llc));
    end
    step();
    exp_llc++;
    checks++;
    if (obs !== exp_vec(1, exp_llc)) begin
      errors++;
      $display("FAIL lock_loss: got %h expected %h", obs, exp_vec(1, exp_llc));
    end
    // Staying unlocked in WAIT_LOCK must not count again.
    step();
    step();
    step();
    checks++;
    if (obs !== exp_vec(1, exp_llc)) begin
      errors++;
      $display("FAIL lock_loss_wait: got %h expected %h", obs, exp_vec(1, exp_llc));
    end
    locked = 1'b1;
    push_relock_trace(22);
    e = 1;
    while (exp_q.size() > 0) begin
      step();
      exp_v = exp_q.pop_front();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL relock edge %0d: got %h expected %h", e, obs, exp_v);
      end
      e++;
    end
  endtask

  task automatic test_resync_holdoff();
    int e;
    locked = 1'b0;
    step();
    step();
    step();
    exp_llc++;
    checks++;
    if (obs !== exp_vec(1, exp_llc)) begin
      errors++;
      $display("FAIL resync_holdoff_drop: got %h expected %h", obs, exp_vec(1, exp_llc));
    end
    locked = 1'b1;
    // Run a few edges past RUN to confirm the ignored request was not queued.
    push_relock_trace(26);
    e = 1;
    while (exp_q.size() > 0) begin
      step();
      sw_resync = (e == 5);
      exp_v = exp_q.pop_front();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL resync_holdoff edge %0d: got %h expected %h", e, obs, exp_v);
      end
      e++;
    end
    sw_resync = 1'b0;
  endtask

  task automatic test_glitch_holdoff();
    int e;
    locked = 1'b0;
    step();
    step();
    step();
    exp_llc++;
    locked = 1'b1;
    for (int k = 0; k < 5; k++) step();
    checks++;
    if (obs !== exp_vec(2, exp_llc)) begin
      errors++;
      $display("FAIL glitch_in_holdoff: got %h expected %h", obs, exp_vec(2, exp_llc));
    end
    locked = 1'b0;
    step();
    step();
    step();
    locked = 1'b1;
    exp_llc++;
    checks++;
    if (obs !== exp_vec(1, exp_llc)) begin
      errors++;
      $display("FAIL glitch_drop: got %h expected %h", obs, exp_vec(1, exp_llc));
    end
    push_relock_trace(22);
    e = 1;
    while (exp_q.size() > 0) begin
      step();
      exp_v = exp_q.pop_front();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL glitch_relock edge %0d: got %h expected %h", e, obs, exp_v);
      end
      e++;
    end
  endtask

  task automatic test_priority();
    int e;
    locked = 1'b0;
    step();
    step();
    sw_resync = 1'b1;
    step();
    sw_resync = 1'b0;
    exp_llc++;
    checks++;
    if (obs !== exp_vec(1, exp_llc)) begin
      errors++;
      $display("FAIL priority: got %h expected %h", obs, exp_vec(1, exp_llc));
    end
    locked = 1'b1;
    push_relock_trace(22);
    e = 1;
    while (exp_q.size() > 0) begin
      step();
      exp_v = exp_q.pop_front();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL priority_relock edge %0d: got %h expected %h", e, obs, exp_v);
      end
      e++;
    end
  endtask

  task automatic test_async_reset();
    int e;
    sw_resync = 1'b1;
    step();
    sw_resync = 1'b0;
    for (int k = 0; k < 5; k++) step();
    checks++;
    if (obs !== exp_vec(4, exp_llc)) begin
      errors++;
      $display("FAIL async_reset_setup: got %h expected %h", obs, exp_vec(4, exp_llc));
    end
    #2 reset_global = 1'b1;
    #1;
    checks++;
    if (obs !== exp_vec(0, 0)) begin
      errors++;
      $display("FAIL async_reset_immediate: got %h expected %h", obs, exp_vec(0, 0));
    end
    exp_llc = 0;
    release_reset();
    push_relock_trace(22);
    e = 1;
    while (exp_q.size() > 0) begin
      step();
      exp_v = exp_q.pop_front();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL async_reset_restart edge %0d: got %h expected %h", e, obs, exp_v);
      end
      e++;
    end
  endtask

  task automatic test_saturation();
    for (int i = 1; i <= 300; i++) begin
      locked = 1'b0;
      step();
      step();
      step();
      exp_llc = (exp_llc < 255) ? exp_llc + 1 : 255;
      if ((i % 25 == 0) || (i == 254) || (i == 255) || (i == 256)) begin
        checks++;
        if (obs !== exp_vec(1, exp_llc)) begin
          errors++;
          $display("FAIL saturation event %0d: got %h expected %h", i, obs, exp_vec(1, exp_llc));
        end
      end
      locked = 1'b1;
      step();
      step();
      step();
      for (int k = 0; k < int'($urandom_range(0, 3)); k++) step();
    end
    checks++;
    if (lock_lost_cnt !== 8'd255) begin
      errors++;
      $display("FAIL saturation_final: got %0d expected 255", lock_lost_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_powerup();
    test_resync();
    test_resync_holdoff();
    test_lock_loss();
    test_glitch_holdoff();
    test_priority();
    test_async_reset();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
